// File: rtl/pid_decoder.sv
// USB PID decoder for the TRCU receive path: complement check, PID classification,
// token->data/handshake sequencing, OUT data toggle tracking and WAIT-state timeout.
module pid_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       fast_enable,
  input  logic [7:0] rx_byte,
  input  logic       bus_reset,
  output logic [3:0] pid,
  output logic       pid_valid,
  output logic       pid_err,
  output logic       is_token,
  output logic       is_data,
  output logic       is_handshake,
  output logic       seq_err,
  output logic       toggle_err,
  output logic       timeout,
  output logic       expect_toggle,
  output logic [1:0] state
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_SOF   = 4'b0101;
  localparam logic [3:0] PID_SETUP = 4'b1101;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    WAIT_DATA = 2'b01,
    WAIT_HS   = 2'b10
  } state_e;

  state_e        state_q, state_d;
  logic          fe_q, fe_d;
  logic [7:0]    byte_q;
  logic [TW-1:0] timer_q, timer_d;
  logic [3:0]    pid_q, pid_d;
  logic          tog_q, tog_d;
  logic          tok_q, tok_d, dat_q, dat_d, hs_q, hs_d;
  logic          pv_q, pv_d, pe_q, pe_d, seq_q, seq_d, tgerr_q, tgerr_d, to_q, to_d;

  logic [3:0]    code;
  logic          cpl_ok, c_tok, c_dat, c_hs, accept;

  // Input capture stage; a byte arriving with bus_reset is never captured.
  assign fe_d   = fast_enable & ~bus_reset;
  assign code   = byte_q[3:0];
  assign cpl_ok = (byte_q[7:4] == ~byte_q[3:0]);

  always_comb begin
    c_tok = 1'b0;
    c_dat = 1'b0;
    c_hs  = 1'b0;
    case (code)
      PID_OUT, PID_IN, PID_SOF, PID_SETUP: c_tok = 1'b1;
      PID_DATA0, PID_DATA1:                c_dat = 1'b1;
      PID_ACK, PID_NAK, PID_STALL:         c_hs  = 1'b1;
      default: ;
    endcase
  end

  assign accept = fe_q & cpl_ok & (c_tok | c_dat | c_hs);

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    tog_d   = tog_q;
    pid_d   = pid_q;
    tok_d   = tok_q;
    dat_d   = dat_q;
    hs_d    = hs_q;
    pv_d    = 1'b0;
    pe_d    = 1'b0;
    seq_d   = 1'b0;
    tgerr_d = 1'b0;
    to_d    = 1'b0;
    if (bus_reset) begin
      state_d = IDLE;
      tog_d   = 1'b0;
      timer_d = '0;
    end else begin
      pe_d = fe_q & ~accept;
      if (accept) begin
        pv_d    = 1'b1;
        pid_d   = code;
        tok_d   = c_tok;
        dat_d   = c_dat;
        hs_d    = c_hs;
        timer_d = '0;
        if (c_tok) begin
          // A token always restarts the transaction, wherever it lands.
          seq_d = (state_q != IDLE);
          case (code)
            PID_OUT:   state_d = WAIT_DATA;
            PID_SETUP: begin
              state_d = WAIT_DATA;
              tog_d   = 1'b0;
            end
            PID_IN:    state_d = WAIT_HS;
            default:   state_d = IDLE;
          endcase
        end else if (c_dat) begin
          state_d = IDLE;
          if (state_q == WAIT_DATA) begin
            if (code[3] == tog_q) tog_d = ~tog_q;
            else                  tgerr_d = 1'b1;
          end else begin
            seq_d = 1'b1;
          end
        end else begin
          state_d = IDLE;
          seq_d   = (state_q != WAIT_HS);
        end
      end else if (state_q != IDLE) begin
        if (timer_q == TMAX) begin
          to_d    = 1'b1;
          state_d = IDLE;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q <= IDLE;
      fe_q    <= 1'b0;
      byte_q  <= '0;
      timer_q <= '0;
      pid_q   <= '0;
      tog_q   <= 1'b0;
      tok_q   <= 1'b0;
      dat_q   <= 1'b0;
      hs_q    <= 1'b0;
      pv_q    <= 1'b0;
      pe_q    <= 1'b0;
      seq_q   <= 1'b0;
      tgerr_q <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      fe_q    <= fe_d;
      byte_q  <= rx_byte;
      timer_q <= timer_d;
      pid_q   <= pid_d;
      tog_q   <= tog_d;
      tok_q   <= tok_d;
      dat_q   <= dat_d;
      hs_q    <= hs_d;
      pv_q    <= pv_d;
      pe_q    <= pe_d;
      seq_q   <= seq_d;
      tgerr_q <= tgerr_d;
      to_q    <= to_d;
    end
  end

  assign pid           = pid_q;
  assign pid_valid     = pv_q;
  assign pid_err       = pe_q;
  assign is_token      = tok_q;
  assign is_data       = dat_q;
  assign is_handshake  = hs_q;
  assign seq_err       = seq_q;
  assign toggle_err    = tgerr_q;
  assign timeout       = to_q;
  assign expect_toggle = tog_q;
  assign state         = state_q;

endmodule

// File: tb/tb_pid_decoder.sv
// Scoreboard bench for pid_decoder: expected output vectors are queued as bytes are
// driven and popped when the registered response appears.
module tb_pid_decoder;

  localparam int unsigned TO = 16;

  localparam logic [7:0] PV = 8'h80, PE = 8'h40, TK = 8'h20, DT = 8'h10,
                         HS = 8'h08, SQ = 8'h04, TG = 8'h02, TM = 8'h01;

  typedef struct packed {
    logic [3:0] pid;
    logic [7:0] fl;
    logic       et;
    logic [1:0] st;
  } out_t;

  logic       clk = 1'b0;
  logic       n_rst, fast_enable, bus_reset;
  logic [7:0] rx_byte;
  logic [3:0] pid;
  logic       pid_valid, pid_err, is_token, is_data, is_handshake;
  logic       seq_err, toggle_err, timeout, expect_toggle;
  logic [1:0] state;

  int   n_cmp = 0;
  int   n_bad = 0;
  out_t sb[$];

  pid_decoder #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .n_rst(n_rst), .fast_enable(fast_enable), .rx_byte(rx_byte),
    .bus_reset(bus_reset), .pid(pid), .pid_valid(pid_valid), .pid_err(pid_err),
    .is_token(is_token), .is_data(is_data), .is_handshake(is_handshake),
    .seq_err(seq_err), .toggle_err(toggle_err), .timeout(timeout),
    .expect_toggle(expect_toggle), .state(state)
  );

  always #5 clk = ~clk;

  function automatic out_t mk(logic [3:0] p, logic [1:0] st, logic et, logic [7:0] fl);
    out_t r;
    r.pid = p; r.st = st; r.et = et; r.fl = fl;
    return r;
  endfunction

  function automatic out_t obs();
    out_t r;
    r.pid = pid;
    r.fl  = {pid_valid, pid_err, is_token, is_data, is_handshake, seq_err, toggle_err, timeout};
    r.et  = expect_toggle;
    r.st  = state;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(logic [7:0] b);
    fast_enable = 1'b1;
    rx_byte     = b;
    tick();
    fast_enable = 1'b0;
  endtask

  task automatic test_reset();
    out_t e, o;
    n_rst = 1'b0; fast_enable = 1'b1; rx_byte = 8'hE1; bus_reset = 1'b0;
    sb.push_back(mk(4'h0, 2'b00, 1'b0, 8'h00));
    tick(); tick();
    e = sb.pop_front(); o = obs(); n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL reset_state: got %h want %h", o, e); end
    n_rst = 1'b1; fast_enable = 1'b0;
    sb.push_back(mk(4'h0, 2'b00, 1'b0, 8'h00));
    tick(); tick();
    e = sb.pop_front(); o = obs(); n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL reset_byte_dropped: got %h want %h", o, e); end
  endtask

  task automatic test_out_data0();
    logic [7:0] b [3];
    out_t       ex [3];
    out_t       e, o;
    b[0] = 8'hE1; ex[0] = mk(4'h1, 2'b01, 1'b0, PV | TK);
    b[1] = 8'hC3; ex[1] = mk(4'h3, 2'b00, 1'b1, PV | DT);
    for (int i = 0; i < 2; i++) begin
      sb.push_back(ex[i]);
      send(b[i]);
      tick();
      e = sb.pop_front(); o = obs(); n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL out_data0[%0d]: got %h want %h", i, o, e); end
    end
    sb.push_back(mk(4'h3, 2'b00, 1'b1, DT));
    tick();
    e = sb.pop_front(); o = obs(); n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL pulse_width: got %h want %h", o, e); end
  endtask

  task automatic test_invalid();
    logic [7:0] b [7];
    out_t       ex [7];
    out_t       e, o;
    b[0] = 8'h11; ex[0] = mk(4'h3, 2'b00, 1'b1, PE | DT);
    b[1] = 8'hF0; ex[1] = mk(4'h3, 2'b00, 1'b1, PE | DT);
    b[2] = 8'h87; ex[2] = mk(4'h3, 2'b00, 1'b1, PE | DT);
    b[3] = 8'h1E; ex[3] = mk(4'hE, 2'b00, 1'b1, PV | HS | SQ);
    b[4] = 8'hE1; ex[4] = mk(4'h1, 2'b01, 1'b1, PV | TK);
    b[5] = 8'h11; ex[5] = mk(4'h1, 2'b01, 1'b1, PE | TK);
    b[6] = 8'h4B; ex[6] = mk(4'hB, 2'b00, 1'b0, PV | DT);
    for (int i = 0; i < 7; i++) begin
      sb.push_back(ex[i]);
      send(b[i]);
      tick();
      e = sb.pop_front(); o = obs(); n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL invalid[%0d] byte %h: got %h want %h", i, b[i], o, e); end
    end
  endtask

  task automatic test_setup_toggle();
    logic [7:0] b [5];
    out_t       ex [5];
    out_t       e, o;
    b[0] = 8'hE1; ex[0] = mk(4'h1, 2'b01, 1'b0, PV | TK);
    b[1] = 8'hC3; ex[1] = mk(4'h3, 2'b00, 1'b1, PV | DT);
    b[2] = 8'h2D; ex[2] = mk(4'hD, 2'b01, 1'b0, PV | TK);
    b[3] = 8'h4B; ex[3] = mk(4'hB, 2'b00, 1'b0, PV | DT | TG);
    b[4] = 8'hD2; ex[4] = mk(4'h2, 2'b00, 1'b0, PV | HS | SQ);
    for (int i = 0; i < 5; i++) begin
      sb.push_back(ex[i]);
      send(b[i]);
      tick();
      e = sb.pop_front(); o = obs(); n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL setup_toggle[%0d] byte %h: got %h want %h", i, b[i], o, e); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b [7];
    out_t       ex [7];
    out_t       e, o;
    b[0] = 8'hE1; ex[0] = mk(4'h1, 2'b01, 1'b0, PV | TK);
    b[1] = 8'hC3; ex[1] = mk(4'h3, 2'b00, 1'b1, PV | DT);
    b[2] = 8'h69; ex[2] = mk(4'h9, 2'b10, 1'b1, PV | TK);
    b[3] = 8'h4B; ex[3] = mk(4'hB, 2'b00, 1'b1, PV | DT | SQ);
    b[4] = 8'h69; ex[4] = mk(4'h9, 2'b10, 1'b1, PV | TK);
    b[5] = 8'hE1; ex[5] = mk(4'h1, 2'b01, 1'b1, PV | TK | SQ);
    b[6] = 8'hC3; ex[6] = mk(4'h3, 2'b00, 1'b1, PV | DT | TG);
    for (int i = 0; i <= 7; i++) begin
      if (i < 7) begin
        sb.push_back(ex[i]);
        fast_enable = 1'b1;
        rx_byte     = b[i];
      end else begin
        fast_enable = 1'b0;
      end
      tick();
      if (i >= 1) begin
        e = sb.pop_front(); o = obs(); n_cmp++;
        if (o !== e) begin n_bad++; $display("FAIL back_to_back[%0d]: got %h want %h", i - 1, o, e); end
      end
    end
    sb.push_back(mk(4'h3, 2'b00, 1'b1, DT));
    tick();
    e = sb.pop_front(); o = obs(); n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL back_to_back_idle: got %h want %h", o, e); end
  endtask

  task automatic test_timeout();
    out_t e, o;
    sb.push_back(mk(4'h9, 2'b10, 1'b1, PV | TK));
    send(8'h69);
    tick();
    e = sb.pop_front(); o = obs(); n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL timeout_enter: got %h want %h", o, e); end
    sb.push_back(mk(4'h9, 2'b10, 1'b1, TK));
    repeat (TO - 1) tick();
    e = sb.pop_front(); o = obs(); n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL timeout_early: got %h want %h", o, e); end
    sb.push_back(mk(4'h9, 2'b00, 1'b1, TK | TM));
    tick();
    e = sb.pop_front(); o = obs(); n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL timeout_fire: got %h want %h", o, e); end
    sb.push_back(mk(4'h9, 2'b00, 1'b1, TK));
    tick();
    e = sb.pop_front(); o = obs(); n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL timeout_single: got %h want %h", o, e); end

    sb.push_back(mk(4'h9, 2'b10, 1'b1, PV | TK));
    send(8'h69);
    tick();
    e = sb.pop_front(); o = obs(); n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL expiry_enter: got %h want %h", o, e); end
    repeat (TO - 2) tick();
    sb.push_back(mk(4'h2, 2'b00, 1'b1, PV | HS));
    send(8'hD2);
    tick();
    e = sb.pop_front(); o = obs(); n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL expiry_ack_wins: got %h want %h", o, e); end
    sb.push_back(mk(4'h2, 2'b00, 1'b1, HS));
    tick();
    e = sb.pop_front(); o = obs(); n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL expiry_no_late: got %h want %h", o, e); end
  endtask

  task automatic test_bus_reset();
    out_t e, o;
    sb.push_back(mk(4'h1, 2'b01, 1'b1, PV | TK));
    send(8'hE1);
    tick();
    e = sb.pop_front(); o = obs(); n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL busrst_pre: got %h want %h", o, e); end
    sb.push_back(mk(4'h1, 2'b00, 1'b0, TK));
    fast_enable = 1'b1; rx_byte = 8'hC3; bus_reset = 1'b1;
    tick();
    fast_enable = 1'b0; bus_reset = 1'b0;
    e = sb.pop_front(); o = obs(); n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL busrst_clear: got %h want %h", o, e); end
    sb.push_back(mk(4'h1, 2'b00, 1'b0, TK));
    tick();
    e = sb.pop_front(); o = obs(); n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL busrst_drop: got %h want %h", o, e); end
    sb.push_back(mk(4'h3, 2'b00, 1'b0, PV | DT | SQ));
    send(8'hC3);
    tick();
    e = sb.pop_front(); o = obs(); n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL busrst_after: got %h want %h", o, e); end
  endtask

  initial begin
    n_rst = 1'b0; fast_enable = 1'b0; rx_byte = '0; bus_reset = 1'b0;
    test_reset();
    test_out_data0();
    test_invalid();
    test_setup_toggle();
    test_back_to_back();
    test_timeout();
    test_bus_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish by 200000");
    $fatal(1, "watchdog");
  end

endmodule
